// File: rtl/uart_rx_bram_loader.sv
// uart_rx_bram_loader
// Receives 8-bit UART frames and writes each one in order into the
// computation input BRAM. A session starts on a rising edge of load_en
// and holds DEPTH bytes. When byte DEPTH-1 is written, load_done pulses
// so the controller can release the compute path.
//
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// between the data bits and the stop bit (8E1, 11-bit frame). When it is
// not defined, frames are 8N1.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   rxd         asynchronous serial input, idle high
//   load_en     session enable level; a rising edge starts a session
//   bram_we     one-cycle BRAM write strobe
//   bram_addr   BRAM write address, valid while bram_we is high
//   bram_wdata  BRAM write data, valid while bram_we is high
//   loading     a session is active and the buffer is not yet full
//   load_done   one-cycle pulse, one cycle after the final write
//   frame_err   sticky framing/parity error, cleared at session start
//   byte_count  bytes written in the current session
module uart_rx_bram_loader #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DEPTH        = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    input  logic                  load_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [7:0]            bram_wdata,
    output logic                  loading,
    output logic                  load_done,
    output logic                  frame_err,
    output logic [ADDR_WIDTH:0]   byte_count
);

    localparam int unsigned           CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0]       HalfCnt  = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0]       LastCnt  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

    // ------------------------------------------------------------------
    // Input synchronizer and edge history (reset to idle-high level)
    // ------------------------------------------------------------------
    logic rxd_meta_q, rxd_s_q, rxd_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            rxd_prev_q <= rxd_s_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_bad_q, parity_bad_d;
    logic            rx_valid;   // good byte in shift_q this cycle
    logic            rx_ferr;    // framing or parity error this cycle

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            parity_bad_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            parity_bad_q <= parity_bad_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        parity_bad_d = parity_bad_q;
        rx_valid     = 1'b0;
        rx_ferr      = 1'b0;

        case (state_q)
            StIdle: begin
                if (rxd_prev_q && !rxd_s_q) begin
                    state_d      = StStart;
                    cnt_d        = '0;
                    parity_bad_d = 1'b0;
                end
            end
            StStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // Start bit gone high again by mid-bit: treat as a glitch.
                    state_d   = rxd_s_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == LastCnt) begin
                    cnt_d     = '0;
                    shift_d   = {rxd_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StStop;
                    // Even parity: the parity bit equals the XOR of the data bits.
                    if (rxd_s_q != ^shift_q) begin
                        parity_bad_d = 1'b1;
                        rx_ferr      = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        state_d  = StIdle;
                        rx_valid = !parity_bad_q;
                    end else begin
                        state_d = StBreak;
                        rx_ferr = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                // A line held low must return high before a new start is seen.
                if (rxd_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    logic                  load_en_q;
    logic                  bram_we_q, bram_we_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [7:0]            bram_wdata_q, bram_wdata_d;
    logic                  loading_q, loading_d;
    logic                  done_pend_q, done_pend_d;
    logic                  load_done_q, load_done_d;
    logic                  frame_err_q, frame_err_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   byte_count_q, byte_count_d;

    logic                  load_rise;
    logic                  active;
    logic [ADDR_WIDTH-1:0] ptr_eff;
    logic [ADDR_WIDTH:0]   cnt_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_en_q    <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            loading_q    <= 1'b0;
            done_pend_q  <= 1'b0;
            load_done_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            wr_ptr_q     <= '0;
            byte_count_q <= '0;
        end else begin
            load_en_q    <= load_en;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            loading_q    <= loading_d;
            done_pend_q  <= done_pend_d;
            load_done_q  <= load_done_d;
            frame_err_q  <= frame_err_d;
            wr_ptr_q     <= wr_ptr_d;
            byte_count_q <= byte_count_d;
        end
    end

    always_comb begin
        load_rise = load_en && !load_en_q;
        // A restart in the same cycle as a byte wins, so that byte lands at 0.
        ptr_eff   = load_rise ? '0 : wr_ptr_q;
        cnt_eff   = load_rise ? '0 : byte_count_q;
        active    = load_en && (load_rise || loading_q);

        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        loading_d    = loading_q;
        done_pend_d  = 1'b0;
        load_done_d  = done_pend_q;
        frame_err_d  = frame_err_q;
        wr_ptr_d     = wr_ptr_q;
        byte_count_d = byte_count_q;

        if (load_rise) begin
            wr_ptr_d     = '0;
            byte_count_d = '0;
            frame_err_d  = 1'b0;
            loading_d    = 1'b1;
        end
        if (!load_en) begin
            loading_d = 1'b0;
        end

        if (rx_valid && active) begin
            bram_we_d    = 1'b1;
            bram_addr_d  = ptr_eff;
            bram_wdata_d = shift_q;
            wr_ptr_d     = ptr_eff + 1'b1;
            byte_count_d = cnt_eff + 1'b1;
            if (ptr_eff == LastAddr) begin
                loading_d   = 1'b0;
                done_pend_d = 1'b1;
            end
        end

        if (rx_ferr) begin
            frame_err_d = 1'b1;
        end
    end

    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign loading    = loading_q;
    assign load_done  = load_done_q;
    assign frame_err  = frame_err_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_uart_rx_bram_loader.sv
// Self-checking bench for uart_rx_bram_loader (CLKS_PER_BIT=16, DEPTH=4).
// Expected writes and status come from a byte-level model of the loader
// session rules; observed writes are collected by a negedge monitor.
module tb_uart_rx_bram_loader;

    localparam int unsigned CPB   = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OutW  = 1 + AW + 8 + 3 + AW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rxd = 1'b1;
    logic          load_en = 1'b0;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_wdata;
    logic          loading;
    logic          load_done;
    logic          frame_err;
    logic [AW:0]   byte_count;
    logic [OutW-1:0] outs;

    always #5 clk = ~clk;

    uart_rx_bram_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .load_en   (load_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_wdata(bram_wdata),
        .loading   (loading),
        .load_done (load_done),
        .frame_err (frame_err),
        .byte_count(byte_count)
    );

    assign outs = {bram_we, bram_addr, bram_wdata, loading, load_done, frame_err, byte_count};

    int vectors = 0;
    int miscompares = 0;

    // Monitor
    int            cyc = 0;
    logic [AW-1:0] obs_addr[$];
    logic [7:0]    obs_data[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            we_cyc = 0;
    int            we_double = 0;
    logic          we_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bram_we) begin
            obs_addr.push_back(bram_addr);
            obs_data.push_back(bram_wdata);
            we_cyc <= cyc;
        end
        if (load_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (bram_we && we_prev) we_double <= we_double + 1;
        we_prev <= bram_we;
    end

    // Reference model of the loader session
    int            m_ptr = 0;
    logic [AW:0]   m_cnt = '0;
    logic          m_loading = 1'b0;
    logic          m_ferr = 1'b0;
    int            m_done = 0;
    logic [AW-1:0] exp_addr[$];
    logic [7:0]    exp_data[$];
    int            base_obs = 0;
    int            base_done = 0;

`ifdef UART_RX_PARITY_EN
    logic bad_parity = 1'b0;
`endif

    task automatic start_check();
        base_obs  = obs_addr.size();
        base_done = done_cnt;
        m_done    = 0;
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic set_load_en(input logic v);
        if (v && !load_en) begin
            m_ptr     = 0;
            m_cnt     = '0;
            m_ferr    = 1'b0;
            m_loading = 1'b1;
        end
        if (!v) m_loading = 1'b0;
        load_en = v;
        repeat (2) @(negedge clk);
    endtask

    task automatic model_byte(input logic [7:0] b, input logic good);
        if (!good) begin
            m_ferr = 1'b1;
        end else if (m_loading) begin
            exp_addr.push_back(AW'(m_ptr));
            exp_data.push_back(b);
            m_ptr++;
            m_cnt++;
            if (m_ptr == DEPTH) begin
                m_loading = 1'b0;
                m_done++;
            end
        end
    endtask

    // Drives one frame starting at a negedge; ends at a negedge on the stop level.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ bad_parity;
        repeat (CPB) @(negedge clk);
`endif
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        load_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rxd = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if (outs !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, outs);
            end
        end
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected 0", outs);
        end
    endtask

    task automatic test_session();
        logic [7:0] pat[4] = '{8'h55, 8'h5A, 8'h5F, 8'h6F};
        start_check();
        set_load_en(1'b1);
        for (int i = 0; i < 4; i++) begin
            send_byte(pat[i], 1'b1);
            model_byte(pat[i], 1'b1);
            repeat (3) @(negedge clk);
        end
        vectors++;
        if (obs_addr.size() - base_obs !== exp_addr.size()) begin
            miscompares++;
            $display("FAIL session writes: got %0d expected %0d",
                     obs_addr.size() - base_obs, exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                vectors++;
                if ({obs_addr[base_obs+i], obs_data[base_obs+i]} !== {exp_addr[i], exp_data[i]}) begin
                    miscompares++;
                    $display("FAIL session write %0d: got %h/%h expected %h/%h", i,
                             obs_addr[base_obs+i], obs_data[base_obs+i], exp_addr[i], exp_data[i]);
                end
            end
        end
        vectors++;
        if ({loading, frame_err, byte_count} !== {m_loading, m_ferr, m_cnt}) begin
            miscompares++;
            $display("FAIL session status: got %b/%b/%0d expected %b/%b/%0d",
                     loading, frame_err, byte_count, m_loading, m_ferr, m_cnt);
        end
        vectors++;
        if (done_cnt - base_done !== m_done) begin
            miscompares++;
            $display("FAIL session load_done count: got %0d expected %0d",
                     done_cnt - base_done, m_done);
        end
        vectors++;
        if (done_cyc !== we_cyc + 1) begin
            miscompares++;
            $display("FAIL session load_done timing: got cycle %0d expected %0d",
                     done_cyc, we_cyc + 1);
        end
    endtask

    task automatic test_glitch();
        set_load_en(1'b0);
        set_load_en(1'b1);
        start_check();
        rxd = 1'b0;
        repeat (6) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        vectors++;
        if ({obs_addr.size() - base_obs, frame_err} !== {32'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL glitch: got writes=%0d frame_err=%b expected 0/0",
                     obs_addr.size() - base_obs, frame_err);
        end
        send_byte(8'hA3, 1'b1);
        model_byte(8'hA3, 1'b1);
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_addr.size() - base_obs !== exp_addr.size()) begin
            miscompares++;
            $display("FAIL glitch writes: got %0d expected %0d",
                     obs_addr.size() - base_obs, exp_addr.size());
        end else begin
            vectors++;
            if ({obs_addr[base_obs], obs_data[base_obs]} !== {exp_addr[0], exp_data[0]}) begin
                miscompares++;
                $display("FAIL glitch write: got %h/%h expected %h/%h",
                         obs_addr[base_obs], obs_data[base_obs], exp_addr[0], exp_data[0]);
            end
        end
    endtask

    task automatic test_frame_err();
        start_check();
        send_byte(8'h12, 1'b0);
        model_byte(8'h12, 1'b0);
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        vectors++;
        if ({obs_addr.size() - base_obs, frame_err} !== {32'd0, m_ferr}) begin
            miscompares++;
            $display("FAIL frame_err: got writes=%0d frame_err=%b expected 0/%b",
                     obs_addr.size() - base_obs, frame_err, m_ferr);
        end
        send_byte(8'h34, 1'b1);
        model_byte(8'h34, 1'b1);
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_addr.size() - base_obs !== exp_addr.size()) begin
            miscompares++;
            $display("FAIL frame_err writes: got %0d expected %0d",
                     obs_addr.size() - base_obs, exp_addr.size());
        end else begin
            vectors++;
            if ({obs_addr[base_obs], obs_data[base_obs]} !== {exp_addr[0], exp_data[0]}) begin
                miscompares++;
                $display("FAIL frame_err next write: got %h/%h expected %h/%h",
                         obs_addr[base_obs], obs_data[base_obs], exp_addr[0], exp_data[0]);
            end
        end
        vectors++;
        if ({loading, frame_err, byte_count} !== {m_loading, m_ferr, m_cnt}) begin
            miscompares++;
            $display("FAIL frame_err status: got %b/%b/%0d expected %b/%b/%0d",
                     loading, frame_err, byte_count, m_loading, m_ferr, m_cnt);
        end
    endtask

    task automatic test_load_drop();
        logic [7:0] b;
        set_load_en(1'b0);
        set_load_en(1'b1);
        start_check();
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1);
            model_byte(b, 1'b1);
            repeat (2) @(negedge clk);
        end
        set_load_en(1'b0);
        send_byte(8'h77, 1'b1);
        model_byte(8'h77, 1'b1);
        repeat (3) @(negedge clk);
        vectors++;
        if ({loading, frame_err, byte_count} !== {m_loading, m_ferr, m_cnt}) begin
            miscompares++;
            $display("FAIL load_drop status: got %b/%b/%0d expected %b/%b/%0d",
                     loading, frame_err, byte_count, m_loading, m_ferr, m_cnt);
        end
        vectors++;
        if (obs_addr.size() - base_obs !== exp_addr.size()) begin
            miscompares++;
            $display("FAIL load_drop writes: got %0d expected %0d",
                     obs_addr.size() - base_obs, exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                vectors++;
                if ({obs_addr[base_obs+i], obs_data[base_obs+i]} !== {exp_addr[i], exp_data[i]}) begin
                    miscompares++;
                    $display("FAIL load_drop write %0d: got %h/%h expected %h/%h", i,
                             obs_addr[base_obs+i], obs_data[base_obs+i], exp_addr[i], exp_data[i]);
                end
            end
        end
        set_load_en(1'b1);
        vectors++;
        if ({loading, frame_err, byte_count} !== {m_loading, m_ferr, m_cnt}) begin
            miscompares++;
            $display("FAIL load_restart status: got %b/%b/%0d expected %b/%b/%0d",
                     loading, frame_err, byte_count, m_loading, m_ferr, m_cnt);
        end
        start_check();
        b = 8'($urandom);
        send_byte(b, 1'b1);
        model_byte(b, 1'b1);
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_addr.size() - base_obs !== 1 ||
            {obs_addr[base_obs], obs_data[base_obs]} !== {exp_addr[0], exp_data[0]}) begin
            miscompares++;
            $display("FAIL load_restart write: got %0d writes, first %h/%h expected %h/%h",
                     obs_addr.size() - base_obs, obs_addr[base_obs], obs_data[base_obs],
                     exp_addr[0], exp_data[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'hC4;
        start_check();
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rst_n     = 1'b0;
        load_en   = 1'b0;
        m_loading = 1'b0;
        m_cnt     = '0;
        m_ferr    = 1'b0;
        @(negedge clk);
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_mid outputs: got %h expected 0", outs);
        end
        repeat (3) @(negedge clk);
        rxd   = 1'b1;
        rst_n = 1'b1;
        repeat (CPB * 12) @(negedge clk);
        vectors++;
        if (obs_addr.size() - base_obs !== 0) begin
            miscompares++;
            $display("FAIL reset_mid aborted byte: got %0d writes expected 0",
                     obs_addr.size() - base_obs);
        end
        set_load_en(1'b1);
        send_byte(b, 1'b1);
        model_byte(b, 1'b1);
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_addr.size() - base_obs !== 1 ||
            {obs_addr[base_obs], obs_data[base_obs]} !== {exp_addr[0], exp_data[0]}) begin
            miscompares++;
            $display("FAIL reset_mid resend: got %0d writes, first %h/%h expected %h/%h",
                     obs_addr.size() - base_obs, obs_addr[base_obs], obs_data[base_obs],
                     exp_addr[0], exp_data[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int s = 0; s < 2; s++) begin
            set_load_en(1'b0);
            set_load_en(1'b1);
            start_check();
            // Two extra bytes land after the buffer is full and must be dropped.
            for (int i = 0; i < DEPTH + 2; i++) begin
                b = 8'($urandom);
                send_byte(b, 1'b1);
                model_byte(b, 1'b1);
                repeat ($urandom_range(1, 20)) @(negedge clk);
            end
            repeat (3) @(negedge clk);
            vectors++;
            if (obs_addr.size() - base_obs !== exp_addr.size()) begin
                miscompares++;
                $display("FAIL random writes session %0d: got %0d expected %0d", s,
                         obs_addr.size() - base_obs, exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    vectors++;
                    if ({obs_addr[base_obs+i], obs_data[base_obs+i]} !== {exp_addr[i], exp_data[i]}) begin
                        miscompares++;
                        $display("FAIL random write %0d: got %h/%h expected %h/%h", i,
                                 obs_addr[base_obs+i], obs_data[base_obs+i],
                                 exp_addr[i], exp_data[i]);
                    end
                end
            end
            vectors++;
            if ({loading, frame_err, byte_count} !== {m_loading, m_ferr, m_cnt}) begin
                miscompares++;
                $display("FAIL random status: got %b/%b/%0d expected %b/%b/%0d",
                         loading, frame_err, byte_count, m_loading, m_ferr, m_cnt);
            end
            vectors++;
            if (done_cnt - base_done !== m_done) begin
                miscompares++;
                $display("FAIL random load_done count: got %0d expected %0d",
                         done_cnt - base_done, m_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        int         dbl;
        set_load_en(1'b0);
        set_load_en(1'b1);
        start_check();
        dbl = we_double;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1);
            model_byte(b, 1'b1);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (obs_addr.size() - base_obs !== exp_addr.size()) begin
            miscompares++;
            $display("FAIL b2b writes: got %0d expected %0d",
                     obs_addr.size() - base_obs, exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                vectors++;
                if ({obs_addr[base_obs+i], obs_data[base_obs+i]} !== {exp_addr[i], exp_data[i]}) begin
                    miscompares++;
                    $display("FAIL b2b write %0d: got %h/%h expected %h/%h", i,
                             obs_addr[base_obs+i], obs_data[base_obs+i], exp_addr[i], exp_data[i]);
                end
            end
        end
        vectors++;
        if (we_double - dbl !== 0) begin
            miscompares++;
            $display("FAIL b2b bram_we width: got %0d multi-cycle strobes expected 0",
                     we_double - dbl);
        end
        vectors++;
        if (done_cnt - base_done !== m_done) begin
            miscompares++;
            $display("FAIL b2b load_done count: got %0d expected %0d",
                     done_cnt - base_done, m_done);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        set_load_en(1'b0);
        set_load_en(1'b1);
        start_check();
        bad_parity = 1'b1;
        send_byte(8'hC4, 1'b1);
        bad_parity = 1'b0;
        model_byte(8'hC4, 1'b0);
        repeat (3) @(negedge clk);
        vectors++;
        if ({obs_addr.size() - base_obs, frame_err} !== {32'd0, m_ferr}) begin
            miscompares++;
            $display("FAIL parity error: got writes=%0d frame_err=%b expected 0/%b",
                     obs_addr.size() - base_obs, frame_err, m_ferr);
        end
        send_byte(8'hC4, 1'b1);
        model_byte(8'hC4, 1'b1);
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_addr.size() - base_obs !== 1 ||
            {obs_addr[base_obs], obs_data[base_obs]} !== {exp_addr[0], exp_data[0]}) begin
            miscompares++;
            $display("FAIL parity good byte: got %0d writes, first %h/%h expected %h/%h",
                     obs_addr.size() - base_obs, obs_addr[base_obs], obs_data[base_obs],
                     exp_addr[0], exp_data[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_session();
        test_glitch();
        test_frame_err();
        test_load_drop();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
